// File: rtl/ob_stream_drain_if.sv
// Row stream between the output-buffer drain and its consumer.
// Master drives data/valid/last, slave drives ready.
interface ob_stream_drain_if #(
   parameter int WIDTH = 8,
   parameter int COL   = 4
);
   logic [COL-1:0][WIDTH-1:0] m_data_o;
   logic                      m_valid_o;
   logic                      m_ready_i;
   logic                      m_last_o;

   modport master (
      output m_data_o,
      output m_valid_o,
      output m_last_o,
      input  m_ready_i
   );

   modport slave (
      input  m_data_o,
      input  m_valid_o,
      input  m_last_o,
      output m_ready_i
   );
endinterface

// File: rtl/ob_stream_drain.sv
// Drains a row range of the output buffer SRAM onto a valid/ready stream.
// Reads are credit-limited so the 2-entry FIFO can never overflow.
module ob_stream_drain #(
   parameter  int WIDTH  = 8,
   parameter  int COL    = 4,
   parameter  int O_SIZE = 256,
   localparam int AW     = $clog2(O_SIZE)
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      start_i,
   input  logic [AW-1:0]             base_addr_i,
   input  logic [AW:0]               num_rows_i,
   output logic                      ob_mem_cenb_o,
   output logic                      ob_mem_wenb_o,
   output logic [AW-1:0]             ob_mem_addr_o,
   input  logic [COL-1:0][WIDTH-1:0] ob_mem_data_i,
   ob_stream_drain_if.master         strm,
   output logic                      busy_o,
   output logic                      done_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef logic [COL-1:0][WIDTH-1:0] row_t;

   state_t        state_q;
   state_t        state_d;
   logic [AW-1:0] addr_q;
   logic [AW-1:0] addr_nxt;
   logic [AW:0]   issue_rem;
   logic [AW:0]   out_rem;
   logic          inflight;
   row_t          fifo_q [2];
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    fifo_cnt;

   logic          load;
   logic          pop;
   logic          push;
   logic          issue;
   logic          last;
   logic [2:0]    occ;
   logic [2:0]    occ_after;

   assign load = (state_q == IDLE) && start_i;
   assign pop  = strm.m_valid_o && strm.m_ready_i;
   assign push = inflight;
   assign last = (out_rem == (AW+1)'(1));

   // Rows already held or on their way, minus the one leaving now.
   assign occ       = {1'b0, fifo_cnt} + {2'b00, inflight};
   assign occ_after = occ - {2'b00, pop};

   assign issue = (state_q == RUN)
                && (issue_rem != '0)
                && (occ_after < 3'd2);

   assign addr_nxt = (addr_q == AW'(O_SIZE - 1))
                   ? '0
                   : addr_q + AW'(1);

   assign ob_mem_cenb_o = ~issue;
   assign ob_mem_wenb_o = 1'b1;
   assign ob_mem_addr_o = addr_q;

   assign strm.m_valid_o = (fifo_cnt != 2'd0);
   assign strm.m_data_o  = fifo_q[rd_ptr];
   assign strm.m_last_o  = strm.m_valid_o && last;

   assign busy_o = (state_q == RUN);
   assign done_o = (state_q == DONE);

   // State register.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a run ends on the handshake that carries last.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               if (num_rows_i == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (pop && last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (!start_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Address and row counters, loaded at start.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         addr_q    <= '0;
         issue_rem <= '0;
         out_rem   <= '0;
      end else if (load) begin
         addr_q    <= base_addr_i;
         issue_rem <= num_rows_i;
         out_rem   <= num_rows_i;
      end else begin
         if (issue) begin
            addr_q    <= addr_nxt;
            issue_rem <= issue_rem - (AW+1)'(1);
         end
         if (pop) begin
            out_rem <= out_rem - (AW+1)'(1);
         end
      end
   end

   // One-cycle read latency: data lands the cycle after issue.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
      end
   end

   // Two-entry FIFO; push and pop may coincide at any fill level.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         fifo_cnt  <= 2'd0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr] <= ob_mem_data_i;
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         unique case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_ob_stream_drain.sv
// Self-checking bench for ob_stream_drain: SRAM model, stream scoreboard,
// cycle-exact hand sequences and a randomized vector table.
module tb_ob_stream_drain;

   localparam int WIDTH  = 8;
   localparam int COL    = 4;
   localparam int O_SIZE = 256;
   localparam int AW     = 8;

   typedef logic [COL-1:0][WIDTH-1:0] row_t;

   typedef struct {
      int base;
      int n;
      int duty;
      int exp_reads;
      int exp_hs;
   } vec_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base = '0;
   logic [AW:0]   nrows = '0;
   logic          cenb;
   logic          wenb;
   logic [AW-1:0] addr;
   row_t          rdata = '0;
   logic          busy;
   logic          done;

   ob_stream_drain_if #(.WIDTH(WIDTH), .COL(COL)) s ();

   ob_stream_drain #(
      .WIDTH(WIDTH),
      .COL(COL),
      .O_SIZE(O_SIZE)
   ) dut (
      .clk_i(clk),
      .rstn_i(rstn),
      .start_i(start),
      .base_addr_i(base),
      .num_rows_i(nrows),
      .ob_mem_cenb_o(cenb),
      .ob_mem_wenb_o(wenb),
      .ob_mem_addr_o(addr),
      .ob_mem_data_i(rdata),
      .strm(s),
      .busy_o(busy),
      .done_o(done)
   );

   always #5 clk = ~clk;

   row_t mem [O_SIZE];

   // SRAM model with one cycle of read latency.
   always @(posedge clk) begin
      if (!cenb) rdata <= mem[addr];
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h required %0h", nm, $time, got, exp);
      end
   endtask

   task automatic fail_evt(string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s at %0t: event seen, required none", nm, $time);
   endtask

   int   exp_addr [$];
   row_t exp_row  [$];
   bit   exp_last [$];
   int   rd_cnt = 0;
   int   hs_cnt = 0;

   task automatic clear_model();
      exp_addr.delete();
      exp_row.delete();
      exp_last.delete();
      rd_cnt = 0;
      hs_cnt = 0;
   endtask

   task automatic load_model(input int b, input int n);
      for (int i = 0; i < n; i++) begin
         exp_addr.push_back((b + i) % O_SIZE);
         exp_row.push_back(mem[(b + i) % O_SIZE]);
         exp_last.push_back(i == n - 1);
      end
   endtask

   logic prev_stall = 1'b0;
   row_t prev_data;
   logic prev_last;

   // Scoreboard: reads, handshakes, occupancy and stall stability.
   always @(negedge clk) begin
      if (!rstn) begin
         prev_stall = 1'b0;
      end else begin
         if (busy) check("occupancy_le_2", 64'((rd_cnt - hs_cnt) <= 2), 64'd1);
         if (!cenb) begin
            if (exp_addr.size() == 0) fail_evt("unexpected_read");
            else check("read_addr", 64'(addr), 64'(exp_addr.pop_front()));
            rd_cnt++;
         end
         if (prev_stall) begin
            check("valid_held", 64'(s.m_valid_o), 64'd1);
            check("data_stable", 64'(s.m_data_o), 64'(prev_data));
            check("last_stable", 64'(s.m_last_o), 64'(prev_last));
         end
         if (s.m_valid_o && s.m_ready_i) begin
            if (exp_row.size() == 0) begin
               fail_evt("unexpected_row");
            end else begin
               check("row_data", 64'(s.m_data_o), 64'(exp_row.pop_front()));
               check("row_last", 64'(s.m_last_o), 64'(exp_last.pop_front()));
            end
            hs_cnt++;
         end
         prev_stall = s.m_valid_o && !s.m_ready_i;
         prev_data  = s.m_data_o;
         prev_last  = s.m_last_o;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outs(string tag);
      check({tag, "_cenb"},  64'(cenb), 64'd1);
      check({tag, "_wenb"},  64'(wenb), 64'd1);
      check({tag, "_addr"},  64'(addr), 64'd0);
      check({tag, "_data"},  64'(s.m_data_o), 64'd0);
      check({tag, "_valid"}, 64'(s.m_valid_o), 64'd0);
      check({tag, "_last"},  64'(s.m_last_o), 64'd0);
      check({tag, "_busy"},  64'(busy), 64'd0);
      check({tag, "_done"},  64'(done), 64'd0);
   endtask

   task automatic do_run(input int b, input int n, input int duty,
                         output int reads, output int hs,
                         output bit seen);
      clear_model();
      load_model(b, n);
      base  = AW'(b);
      nrows = (AW+1)'(n);
      start = 1'b1;
      s.m_ready_i = ($urandom_range(99) < duty);
      seen = 1'b0;
      for (int c = 0; c < 3000 && !seen; c++) begin
         cyc();
         start = 1'b0;
         s.m_ready_i = ($urandom_range(99) < duty);
         if (done) seen = 1'b1;
      end
      s.m_ready_i = 1'b1;
      cyc();
      cyc();
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_done", 64'(done), 64'd0);
      check("wenb_high", 64'(wenb), 64'd1);
      check("rows_left", 64'(exp_row.size()), 64'd0);
      reads = rd_cnt;
      hs    = hs_cnt;
   endtask

   vec_t tbl [7];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  rd;
      int  hs;
      bit  seen;
      int  k;

      tbl[0] = '{base: 0,   n: 4,   duty: 100, exp_reads: 4,   exp_hs: 4};
      tbl[1] = '{base: 0,   n: 16,  duty: 40,  exp_reads: 16,  exp_hs: 16};
      tbl[2] = '{base: 254, n: 4,   duty: 100, exp_reads: 4,   exp_hs: 4};
      tbl[3] = '{base: 0,   n: 0,   duty: 100, exp_reads: 0,   exp_hs: 0};
      tbl[4] = '{base: 37,  n: 256, duty: 60,  exp_reads: 256, exp_hs: 256};
      tbl[5] = '{base: 255, n: 1,   duty: 30,  exp_reads: 1,   exp_hs: 1};
      tbl[6] = '{base: 200, n: 100, duty: 85,  exp_reads: 100, exp_hs: 100};

      for (int r = 0; r < O_SIZE; r++) begin
         mem[r] = {COL{8'(r + 1)}};
      end

      s.m_ready_i = 1'b0;
      cyc();
      cyc();
      check_reset_outs("reset");
      rstn = 1'b1;
      cyc();

      // Basic run, cycle exact.
      clear_model();
      load_model(0, 4);
      s.m_ready_i = 1'b1;
      base  = '0;
      nrows = 9'd4;
      start = 1'b1;
      for (int c = 0; c <= 7; c++) begin
         @(negedge clk);
         check($sformatf("basic_valid_c%0d", c), 64'(s.m_valid_o),
               64'(c >= 3 && c <= 6));
         check($sformatf("basic_last_c%0d", c), 64'(s.m_last_o), 64'(c == 6));
         check($sformatf("basic_cenb_c%0d", c), 64'(cenb),
               64'(!(c >= 1 && c <= 4)));
         check($sformatf("basic_busy_c%0d", c), 64'(busy),
               64'(c >= 1 && c <= 6));
         check($sformatf("basic_done_c%0d", c), 64'(done), 64'(c == 7));
         if (c >= 3 && c <= 6) begin
            check($sformatf("basic_data_c%0d", c), 64'(s.m_data_o),
                  64'({COL{8'(c - 2)}}));
         end
         if (c == 1) start = 1'b0;
      end
      cyc();
      check("basic_reads", 64'(rd_cnt), 64'd4);
      check("basic_hs", 64'(hs_cnt), 64'd4);

      // Empty run: done in cycle 1, no SRAM access.
      clear_model();
      nrows = '0;
      start = 1'b1;
      for (int c = 0; c <= 2; c++) begin
         @(negedge clk);
         check($sformatf("empty_done_c%0d", c), 64'(done), 64'(c == 1));
         check($sformatf("empty_cenb_c%0d", c), 64'(cenb), 64'd1);
         check($sformatf("empty_valid_c%0d", c), 64'(s.m_valid_o), 64'd0);
         if (c == 1) start = 1'b0;
      end
      cyc();

      // Reset mid-run after two handshakes.
      clear_model();
      load_model(0, 8);
      s.m_ready_i = 1'b1;
      base  = '0;
      nrows = 9'd8;
      start = 1'b1;
      cyc();
      start = 1'b0;
      k = 0;
      while (k < 50 && hs_cnt < 2) begin
         @(negedge clk);
         k++;
      end
      check("midrun_two_hs", 64'(hs_cnt), 64'd2);
      #2;
      rstn = 1'b0;
      #1;
      check_reset_outs("async_reset");
      clear_model();
      cyc();
      cyc();
      rstn = 1'b1;
      cyc();
      do_run(10, 3, 100, rd, hs, seen);
      check("after_reset_done", 64'(seen), 64'd1);
      check("after_reset_reads", 64'(rd), 64'd3);
      check("after_reset_hs", 64'(hs), 64'd3);

      // Start held high through DONE must not restart.
      clear_model();
      load_model(50, 3);
      s.m_ready_i = 1'b1;
      base  = 8'd50;
      nrows = 9'd3;
      start = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         cyc();
         if (done) seen = 1'b1;
      end
      check("level_done_seen", 64'(seen), 64'd1);
      for (int c = 0; c < 10; c++) begin
         cyc();
         check("level_done_held", 64'(done), 64'd1);
      end
      check("level_reads", 64'(rd_cnt), 64'd3);
      check("level_hs", 64'(hs_cnt), 64'd3);
      start = 1'b0;
      cyc();
      check("level_idle_done", 64'(done), 64'd0);
      check("level_idle_busy", 64'(busy), 64'd0);
      do_run(60, 5, 50, rd, hs, seen);
      check("level_rerun_done", 64'(seen), 64'd1);
      check("level_rerun_reads", 64'(rd), 64'd5);
      check("level_rerun_hs", 64'(hs), 64'd5);

      // Randomized backpressure vectors.
      for (int v = 0; v < 7; v++) begin
         do_run(tbl[v].base, tbl[v].n, tbl[v].duty, rd, hs, seen);
         check($sformatf("vec%0d_done", v), 64'(seen), 64'd1);
         check($sformatf("vec%0d_reads", v), 64'(rd), 64'(tbl[v].exp_reads));
         check($sformatf("vec%0d_hs", v), 64'(hs), 64'(tbl[v].exp_hs));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ob_stream_drain.md
# ob_stream_drain

Downstream stage of the matrix-multiply core. Once the core raises `done_o`, this block reads a programmable range of rows from the output buffer SRAM through the core's memory-port style (active-low enables, 1-cycle read latency). It delivers the rows in order on a valid/ready stream with a last-row marker, and uses a 2-entry credit-controlled FIFO so that backpressure never loses or duplicates data.

## Interface
- `WIDTH`, 8, bits per output element
- `COL`, 4, elements per output row (one SRAM word)
- `O_SIZE`, 256, output buffer depth in rows
- `clk_i` input 1: clock, all state on rising edge
- `rstn_i` input 1: reset, asynchronous, active-low
- `start_i` input 1: level start; sampled only in IDLE; must return to 0 before a new run
- `base_addr_i` input $clog2(O_SIZE): first row address, latched at start
- `num_rows_i` input $clog2(O_SIZE)+1: row count, 0..O_SIZE, latched at start
- `ob_mem_cenb_o` output 1: SRAM enable, active low
- `ob_mem_wenb_o` output 1: SRAM write enable, active low; tied 1 (read only)
- `ob_mem_addr_o` output $clog2(O_SIZE): SRAM address
- `ob_mem_data_i` input [COL-1:0][WIDTH-1:0]: SRAM read data, valid the cycle after an enabled read
- `m_data_o` output [COL-1:0][WIDTH-1:0]: stream row
- `m_valid_o` output 1: stream valid
- `m_ready_i` input 1: stream ready
- `m_last_o` output 1: high with the final row of a run
- `busy_o` output 1: high in RUN
- `done_o` output 1: high in DONE

## Operation
- FSM has three states: IDLE, RUN, DONE.
  - IDLE to RUN: `start_i`=1 and `num_rows_i`≠0. The block latches the base address into `addr_q` and the row count into `issue_rem` and `out_rem`.
  - IDLE to DONE: `start_i`=1 and `num_rows_i`=0. No SRAM access occurs.
  - RUN to DONE: the handshake that carries `m_last_o`.
  - DONE to IDLE: `start_i`=0. While `start_i` stays high in DONE, no restart occurs.
- Read issue:
  - `pop` = `m_valid_o` & `m_ready_i`.
  - `ob_mem_cenb_o` = 0 only when state is RUN, `issue_rem`≠0, and (`fifo_cnt` + `inflight` − `pop`) < 2.
  - This enable is combinational from `m_ready_i`, and that path is accepted.
  - `ob_mem_addr_o` = `addr_q`. On each issue, `addr_q` increments modulo O_SIZE (natural wrap, so 255 is followed by 0) and `issue_rem` decrements.
- `inflight` is a 1-bit flag, set on the cycle a read is issued. The next cycle, `ob_mem_data_i` is written into the FIFO.
- FIFO:
  - 2 entries with read and write pointers and `fifo_cnt` 0..2.
  - Push and pop in the same cycle are allowed at any count, including 2 with pop.
  - Overflow is impossible by the credit rule.
- `m_valid_o` = `fifo_cnt`≠0. `m_data_o` = FIFO head.
- `m_data_o` and `m_last_o` stay stable while `m_valid_o`=1 and `m_ready_i`=0.
- `m_last_o` = `m_valid_o` & (`out_rem`==1). `out_rem` decrements on each `pop`.
- `m_ready_i` is ignored when `m_valid_o`=0.
- `ob_mem_wenb_o` is constantly 1.
- When `rstn_i` is asserted at any time, including mid-run, the block immediately returns to IDLE: FIFO emptied, `inflight` cleared, counters zeroed. Rows still in flight are discarded.

## Timing
- Reset values: `ob_mem_cenb_o`=1, `ob_mem_wenb_o`=1, `ob_mem_addr_o`=0, `m_data_o`=0, `m_valid_o`=0, `m_last_o`=0, `busy_o`=0, `done_o`=0.
- Run timeline, with `start_i` first seen high in cycle 0:
  - Cycle 1: RUN, first read issued.
  - Cycle 2: data captured.
  - Cycle 3: `m_valid_o`=1.
- Throughput is 1 row/cycle when `m_ready_i`=1.
- The run produces exactly N handshakes and N reads.
- `done_o` rises the cycle after the last handshake.
- With N=0, `done_o` rises in cycle 1.
- Under backpressure, at most 2 rows are buffered.
- When `m_ready_i` rises again, the next `m_valid_o` row is available in the same cycle, with no bubble while the FIFO is non-empty.

## Test plan
- **Basic run:** preload row r with value {COL{r+1}}, `base_addr_i`=0, N=4, `m_ready_i`=1.
  - `m_valid_o` high in cycles 3–6 with data 0x01010101, 0x02020202, 0x03030303, 0x04040404.
  - `m_last_o` is high only in cycle 6, and `done_o`=1 from cycle 7.
- **Backpressure:** N=16, `m_ready_i` pseudo-random at about 40% duty.
  - All 16 rows arrive in order with no duplicates.
  - (`fifo_cnt` + `inflight`) never exceeds 2.
  - Data and last stay stable during stalls.
  - Exactly 16 cycles have `ob_mem_cenb_o`=0.
- **Wrap:** `base_addr_i`=254, N=4.
  - Read addresses are 254, 255, 0, 1, and the rows are delivered in that order.
- **Empty run:** N=0.
  - `ob_mem_cenb_o` stays 1, `m_valid_o` stays 0, and `done_o`=1 in cycle 1.
- **Reset mid-run:** assert `rstn_i`=0 after 2 of 8 handshakes.
  - All outputs take their reset values asynchronously.
  - A new run with `base_addr_i`=10 and N=3 then delivers rows 10–12 correctly.
- **Start level rule:** hold `start_i`=1 after DONE.
  - No new reads occur and `done_o` stays 1.
  - Dropping `start_i` to 0 returns the block to IDLE, and raising it again starts a fresh run.
